// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings and helpers for the multi-cycle
//               multiply/divide engine (operation codes, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation encodings presented on op_i
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // FSM state encodings. A divide by zero resolves at accept time and
    // goes straight to ST_DONE, so no separate state is needed for it.
    localparam int         MD_STATE_W = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MUL     = 2'd1;
    localparam logic [1:0] ST_DIV     = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Bit 1 of the op code selects the divider
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Bit 0 clear means two's-complement operands
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit_div_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_core
// Description : One restoring-division step. The dividend is shifted out of
//               the top of the quotient register into the partial remainder;
//               the new quotient bit enters at the bottom.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    // Partial remainder stays below the divisor, so one extra bit is enough
    // and the top bit of the difference acts as the borrow.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign w_fits  = ~w_diff[WIDTH];

    assign o_rem = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule : div_iter_core
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle MULT/MULTU/DIV/DIVU engine producing {HI,LO}
//               with start/done handshake, flush and defined divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_STEP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int ITER   = WIDTH / DIV_STEP;
    localparam int PIPE_N = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
    localparam int CNT_W  = $clog2(ITER + MUL_LATENCY + 1);

    logic [MD_STATE_W-1:0] r_state;
    logic [CNT_W-1:0]      r_cnt;

    logic [WIDTH-1:0]      r_rem;
    logic [WIDTH-1:0]      r_quo;
    logic [WIDTH-1:0]      r_dvs;
    logic                  r_qneg;
    logic                  r_rneg;

    logic [2*WIDTH-1:0]    r_pipe [PIPE_N];

    logic [WIDTH-1:0]      r_hi;
    logic [WIDTH-1:0]      r_lo;
    logic                  r_dz;

    logic                  w_busy;
    logic                  w_accept;
    logic                  w_is_div;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [WIDTH-1:0]      w_a_mag;
    logic [WIDTH-1:0]      w_b_mag;
    logic                  w_b_zero;
    logic [2*WIDTH-1:0]    w_ax;
    logic [2*WIDTH-1:0]    w_bx;
    logic [2*WIDTH-1:0]    w_prod;
    logic                  w_mul_last;
    logic                  w_div_last;
    logic [WIDTH-1:0]      w_rem_c [DIV_STEP+1];
    logic [WIDTH-1:0]      w_quo_c [DIV_STEP+1];
    logic [WIDTH-1:0]      w_q_fin;
    logic [WIDTH-1:0]      w_r_fin;

    // ---------------------------------------------------------------------
    // Request decode: operands are only looked at on the accept edge
    // ---------------------------------------------------------------------
    assign w_busy   = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign w_accept = start_i && !flush_i && !w_busy;
    assign w_is_div = md_is_div(op_i);
    assign w_a_neg  = md_is_signed(op_i) && operand_a_i[WIDTH-1];
    assign w_b_neg  = md_is_signed(op_i) && operand_b_i[WIDTH-1];
    // Magnitude of MIN wraps to itself, which is the correct unsigned value
    assign w_a_mag  = w_a_neg ? -operand_a_i : operand_a_i;
    assign w_b_mag  = w_b_neg ? -operand_b_i : operand_b_i;
    assign w_b_zero = (operand_b_i == '0);

    // Sign-extending to 2*WIDTH makes one unsigned multiplier serve both ops
    assign w_ax   = {{WIDTH{w_a_neg}}, operand_a_i};
    assign w_bx   = {{WIDTH{w_b_neg}}, operand_b_i};
    assign w_prod = w_ax * w_bx;

    assign w_mul_last = (r_state == ST_MUL) && (r_cnt == CNT_W'(PIPE_N - 1));
    assign w_div_last = (r_state == ST_DIV) && (r_cnt == CNT_W'(ITER - 1));

    // ---------------------------------------------------------------------
    // Divider datapath: DIV_STEP restoring steps chained per clock
    // ---------------------------------------------------------------------
    assign w_rem_c[0] = r_rem;
    assign w_quo_c[0] = r_quo;

    for (genvar g = 0; g < DIV_STEP; g++) begin : g_step
        div_iter_core #(
            .WIDTH (WIDTH)
        ) u_iter (
            .i_rem (w_rem_c[g]),
            .i_quo (w_quo_c[g]),
            .i_dvs (r_dvs),
            .o_rem (w_rem_c[g+1]),
            .o_quo (w_quo_c[g+1])
        );
    end

    // Sign correction applied on the way into hi/lo in the final iteration
    assign w_q_fin = r_qneg ? -w_quo_c[DIV_STEP] : w_quo_c[DIV_STEP];
    assign w_r_fin = r_rneg ? -w_rem_c[DIV_STEP] : w_rem_c[DIV_STEP];

    // Control FSM and shared iteration counter; flush overrides everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_MUL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_div_last) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept, giving back-to-back issue
                    if (start_i) begin
                        r_cnt <= '0;
                        if (w_is_div) begin
                            r_state <= w_b_zero ? ST_DONE : ST_DIV;
                        end else begin
                            r_state <= (MUL_LATENCY == 1) ? ST_DONE : ST_MUL;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Divider working registers: load magnitudes on accept, iterate in DIV
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (w_accept) begin
            r_rem  <= '0;
            r_quo  <= w_a_mag;
            r_dvs  <= w_b_mag;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
        end else if (r_state == ST_DIV) begin
            r_rem  <= w_rem_c[DIV_STEP];
            r_quo  <= w_quo_c[DIV_STEP];
        end
    end

    // Product register plus free-running retiming stages; FSM picks the tap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_N; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < PIPE_N; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Result registers: written only on the edge that enters the done cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
            r_dz <= 1'b0;
        end else if (w_accept && w_is_div && w_b_zero) begin
            r_hi <= operand_a_i;
            r_lo <= '1;
            r_dz <= 1'b1;
        end else if (w_accept && !w_is_div && (MUL_LATENCY == 1)) begin
            {r_hi, r_lo} <= w_prod;
            r_dz <= 1'b0;
        end else if (w_mul_last && !flush_i) begin
            {r_hi, r_lo} <= r_pipe[PIPE_N-1];
            r_dz <= 1'b0;
        end else if (w_div_last && !flush_i) begin
            r_hi <= w_r_fin;
            r_lo <= w_q_fin;
            r_dz <= 1'b0;
        end
    end

    assign busy_o     = w_busy;
    assign done_o     = (r_state == ST_DONE);
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;
    assign div_zero_o = r_dz;

endmodule : muldiv_unit
`default_nettype wire
